// File: rtl/elastic_stage_reg_if.sv
// Valid/ready stream bundle carrying a data and a control payload.
// master drives valid/data/ctrl and samples ready; slave is the mirror.
interface elastic_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/elastic_stage_reg.sv
// DEPTH-entry elastic pipeline register (FIFO) between two core stages.
// Ports: clk, rst (sync, active-high), flush; in_if (slave: valid/ready/
// data/ctrl from upstream); out_if (master: head entry to downstream);
// count = current occupancy 0..DEPTH.
module elastic_stage_reg #(
    parameter int  DATA_W = 64,
    parameter int  CTRL_W = 8,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    elastic_stage_reg_if.slave  in_if,
    elastic_stage_reg_if.master out_if,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic push;
    logic pop;
    logic wr_en;

    // Readiness looks only at registered occupancy, so a full buffer
    // refuses a push even when the head is popped in the same cycle.
    assign in_if.ready  = (count_q != FULL);
    assign out_if.valid = (count_q != '0);

    // Invalid slots present a bubble: payload forced to zero.
    assign out_if.data = out_if.valid ? data_q[rd_ptr_q] : '0;
    assign out_if.ctrl = out_if.valid ? ctrl_q[rd_ptr_q] : '0;

    assign count = count_q;

    assign push  = in_if.valid & in_if.ready;
    assign pop   = out_if.valid & out_if.ready;
    assign wr_en = push & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            // Storage survives a flush; out_valid=0 hides stale entries.
            if (wr_en) begin
                data_q[wr_ptr_q] <= in_if.data;
                ctrl_q[wr_ptr_q] <= in_if.ctrl;
            end
        end
    end

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed bench for elastic_stage_reg at DEPTH 2, 3 and 1.
// Reset, streaming, back-pressure, flush, pointer wrap, half-rate mode.
module tb_elastic_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic fl2, fl3, fl1;
    logic [1:0] c2;
    logic [1:0] c3;
    logic [0:0] c1;

    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) i2 ();
    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) o2 ();
    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) i3 ();
    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) o3 ();
    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) i1 ();
    elastic_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) o1 ();

    elastic_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(fl2),
        .in_if(i2), .out_if(o2), .count(c2)
    );
    elastic_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(fl3),
        .in_if(i3), .out_if(o3), .count(c3)
    );
    elastic_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(fl1),
        .in_if(i1), .out_if(o1), .count(c1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] s2 [3];
    int pushed, popped, occ, maxc, nxt, exp_out;
    logic do_pop, do_push;

    initial begin
        rst = 1'b1;
        fl2 = 1'b0; fl3 = 1'b0; fl1 = 1'b0;
        i2.valid = 1'b0; i2.data = '0; i2.ctrl = '0; o2.ready = 1'b0;
        i3.valid = 1'b0; i3.data = '0; i3.ctrl = '0; o3.ready = 1'b0;
        i1.valid = 1'b0; i1.data = '0; i1.ctrl = '0; o1.ready = 1'b0;

        // Reset held two cycles with a pending push
        i2.valid = 1'b1; i2.data = 64'h55; i2.ctrl = 8'h55;
        step();
        step();
        rst = 1'b0;
        i2.valid = 1'b0;
        check("rst_count", c2, 0);
        check("rst_oval", o2.valid, 0);
        check("rst_octrl", o2.ctrl, 0);
        check("rst_odata", o2.data, 0);
        check("rst_irdy", i2.ready, 1);

        // Streaming at full throughput
        s2[0] = 64'h11; s2[1] = 64'h22; s2[2] = 64'h33;
        o2.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i2.valid = 1'b1;
            i2.data  = s2[i];
            i2.ctrl  = s2[i][7:0];
            step();
            check("str_data", o2.data, s2[i]);
            check("str_ctrl", o2.ctrl, s2[i] & 64'hff);
            check("str_count", c2, 1);
            check("str_irdy", i2.ready, 1);
        end
        i2.valid = 1'b0;
        step();
        check("str_drain_cnt", c2, 0);
        check("str_drain_val", o2.valid, 0);

        // Back-pressure
        o2.ready = 1'b0;
        i2.valid = 1'b1; i2.data = 64'hA; i2.ctrl = 8'hA;
        step();
        check("bp_d1", o2.data, 64'hA);
        check("bp_c1", c2, 1);
        check("bp_r1", i2.ready, 1);
        i2.data = 64'hB; i2.ctrl = 8'hB;
        step();
        check("bp_d2", o2.data, 64'hA);
        check("bp_c2", c2, 2);
        check("bp_r2", i2.ready, 0);
        i2.data = 64'hC; i2.ctrl = 8'hC;
        step();
        check("bp_d3", o2.data, 64'hA);
        check("bp_ctl3", o2.ctrl, 64'hA);
        check("bp_c3", c2, 2);
        check("bp_r3", i2.ready, 0);
        o2.ready = 1'b1;
        step();
        check("bp_d4", o2.data, 64'hB);
        check("bp_c4", c2, 1);
        check("bp_r4", i2.ready, 1);
        step();
        check("bp_d5", o2.data, 64'hC);
        check("bp_c5", c2, 1);
        i2.valid = 1'b0;
        step();
        check("bp_c6", c2, 0);
        check("bp_v6", o2.valid, 0);

        // Flush a full buffer while a push is offered
        o2.ready = 1'b0;
        i2.valid = 1'b1; i2.data = 64'hE1; i2.ctrl = 8'hE1;
        step();
        i2.data = 64'hE2; i2.ctrl = 8'hE2;
        step();
        check("fl_pre_cnt", c2, 2);
        fl2 = 1'b1;
        i2.data = 64'hD; i2.ctrl = 8'hD;
        step();
        fl2 = 1'b0;
        i2.valid = 1'b0;
        check("fl_cnt", c2, 0);
        check("fl_val", o2.valid, 0);
        check("fl_ctrl", o2.ctrl, 0);
        check("fl_data", o2.data, 0);
        check("fl_irdy", i2.ready, 1);
        o2.ready = 1'b1;
        step();
        check("fl_noD", o2.valid, 0);
        i2.valid = 1'b1; i2.data = 64'h77; i2.ctrl = 8'h77;
        step();
        check("fl_fresh_d", o2.data, 64'h77);
        check("fl_fresh_c", c2, 1);
        i2.valid = 1'b0;
        step();
        check("fl_fresh_e", c2, 0);

        // Pointer wrap at DEPTH=3 with toggling out_ready
        pushed = 1; popped = 0; occ = 0; maxc = 0;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            o3.ready = (cyc % 2 == 0);
            i3.valid = (pushed <= 10);
            i3.data  = 64'(pushed);
            i3.ctrl  = 8'(pushed);
            do_pop  = o3.valid & o3.ready;
            do_push = i3.valid & i3.ready;
            if (do_pop) check("wrap_order", o3.data, 64'(popped + 1));
            step();
            if (do_push) begin
                pushed++;
                occ++;
            end
            if (do_pop) begin
                popped++;
                occ--;
            end
            check("wrap_count", c3, 64'(occ));
            if (int'(c3) > maxc) maxc = int'(c3);
        end
        i3.valid = 1'b0;
        check("wrap_popped", 64'(popped), 10);
        check("wrap_pushed", 64'(pushed), 11);
        check("wrap_max_le3", 64'(maxc <= 3), 1);

        // DEPTH=1 half throughput
        o1.ready = 1'b1;
        nxt = 1; exp_out = 1;
        for (int k = 1; k <= 8; k++) begin
            i1.valid = 1'b1;
            i1.data  = 64'(nxt);
            i1.ctrl  = 8'(nxt);
            if (o1.valid) begin
                check("d1_data", o1.data, 64'(exp_out));
                exp_out++;
            end
            do_push = i1.ready;
            step();
            if (do_push) nxt++;
            check("d1_irdy", i1.ready, 64'(k % 2 == 0));
        end
        i1.valid = 1'b0;
        check("d1_accepts", 64'(nxt - 1), 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
